// File: rtl/sb_pkg.sv
// sb_pkg: shared sizes and types for the register scoreboard.
package sb_pkg;
    localparam int NREGS = 8;
    localparam int REG_W = $clog2(NREGS);
    localparam int CNT_W = 2;
    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;
    localparam sb_cnt_t CNT_MAX = sb_cnt_t'((1 << CNT_W) - 1);
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode issue, write-back retire and flush bundle with scoreboard responses.
interface reg_scoreboard_if;
    import sb_pkg::*;
    logic             issue_valid;
    logic             issue_regwrite;
    reg_idx_t         issue_rd;
    reg_idx_t         issue_rs;
    logic             issue_rs_used;
    reg_idx_t         issue_rt;
    logic             issue_rt_used;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    logic             flush;
    logic             stall;
    logic [NREGS-1:0] busy;
    logic             err;
    modport master (
        output issue_valid, issue_regwrite, issue_rd, issue_rs, issue_rs_used,
               issue_rt, issue_rt_used, wb_valid, wb_rd, flush,
        input  stall, busy, err
    );
    modport slave (
        input  issue_valid, issue_regwrite, issue_rd, issue_rs, issue_rs_used,
               issue_rt, issue_rt_used, wb_valid, wb_rd, flush,
        output stall, busy, err
    );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter; simultaneous inc and dec cancel.
module sb_counter
    import sb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    inc,
    input  logic    dec,
    output sb_cnt_t cnt,
    output logic    nonzero,
    output logic    underflow
);
    sb_cnt_t r_cnt;
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else if (inc && !dec && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + sb_cnt_t'(1);
        else if (dec && !inc && r_cnt != '0)
            r_cnt <= r_cnt - sb_cnt_t'(1);
    end
    assign cnt       = r_cnt;
    assign nonzero   = r_cnt != '0;
    assign underflow = dec && r_cnt == '0;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracking with RAW/saturation stall and sticky underflow error.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle write-back of the last pending write clear a source hazard.
module reg_scoreboard
    import sb_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);
    sb_cnt_t          w_cnt [NREGS];
    logic [NREGS-1:0] w_inc, w_dec, w_uf, w_busy;
    logic             w_rs_byp, w_rt_byp, w_rs_haz, w_rt_haz, w_sat, w_stall, w_accept;
    logic             r_err;
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_rs_byp = sb.wb_valid && sb.wb_rd == sb.issue_rs && w_cnt[sb.issue_rs] == sb_cnt_t'(1);
    assign w_rt_byp = sb.wb_valid && sb.wb_rd == sb.issue_rt && w_cnt[sb.issue_rt] == sb_cnt_t'(1);
`else
    assign w_rs_byp = 1'b0;
    assign w_rt_byp = 1'b0;
`endif
    // Hazards use pre-increment counts, so rd == rs never self-stalls.
    assign w_rs_haz = sb.issue_rs_used && w_cnt[sb.issue_rs] != '0 && !w_rs_byp;
    assign w_rt_haz = sb.issue_rt_used && w_cnt[sb.issue_rt] != '0 && !w_rt_byp;
    assign w_sat    = sb.issue_regwrite && w_cnt[sb.issue_rd] == CNT_MAX;
    assign w_stall  = sb.issue_valid && (w_rs_haz || w_rt_haz || w_sat);
    assign w_accept = sb.issue_valid && !w_stall && !sb.flush;
    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
        assign w_inc[i] = w_accept && sb.issue_regwrite && sb.issue_rd == reg_idx_t'(i);
        assign w_dec[i] = sb.wb_valid && !sb.flush && sb.wb_rd == reg_idx_t'(i);
        sb_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clr       (sb.flush),
            .inc       (w_inc[i]),
            .dec       (w_dec[i]),
            .cnt       (w_cnt[i]),
            .nonzero   (w_busy[i]),
            .underflow (w_uf[i])
        );
    end
    always_ff @(posedge clk) begin
        r_err <= !rst && (r_err || |w_uf);
    end
    assign sb.stall = w_stall;
    assign sb.busy  = w_busy;
    assign sb.err   = r_err;
endmodule
